// File: rtl/down_counter_pkg.sv
//------------------------------------------------------------------------------
// Module   : down_counter_pkg
// Brief    : Shared state encoding for the loadable countdown counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package down_counter_pkg;

  localparam int StateWidth = 2;

  localparam logic [StateWidth-1:0] STATE_IDLE = 2'd0;
  localparam logic [StateWidth-1:0] STATE_RUN  = 2'd1;
  localparam logic [StateWidth-1:0] STATE_DONE = 2'd2;

  typedef enum logic [StateWidth-1:0] {
    ST_IDLE = STATE_IDLE,
    ST_RUN  = STATE_RUN,
    ST_DONE = STATE_DONE
  } state_e;

endpackage

`default_nettype wire

// File: rtl/down_counter_decrementer.sv
//------------------------------------------------------------------------------
// Module   : down_counter_decrementer
// Brief    : Combinational Width-bit decrement (adds all-ones, carry dropped).
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module down_counter_decrementer #(
  parameter int Width = 32
) (
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out
);

  assign out = in + {Width{1'b1}};

endmodule

`default_nettype wire

// File: rtl/down_counter.sv
//------------------------------------------------------------------------------
// Module   : down_counter
// Brief    : Loadable countdown counter with busy/zero/done status; stops at 0.
//            DOWN_COUNTER_AUTO_RELOAD_EN turns it into a periodic ticker.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module down_counter
  import down_counter_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             go,
  input  logic [Width-1:0] in,
  output logic [Width-1:0] out,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  state_e           state;
  state_e           state_next;
  logic [Width-1:0] count_dec;
  logic [Width-1:0] count_next;
  logic             count_en;
  logic             done_next;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
  logic [Width-1:0] reload;

  always_ff @(posedge clock) begin
    if (reset) begin
      reload <= '0;
    end else if (load) begin
      reload <= in;
    end
  end
`endif

  down_counter_decrementer #(
    .Width (Width)
  ) u_dec (
    .in  (out),
    .out (count_dec)
  );

  assign busy     = (state == ST_RUN);
  assign zero     = (out == '0);
  assign count_en = load | (busy & go);

  always_ff @(posedge clock) begin
    if (reset) begin
      out <= '0;
    end else if (count_en) begin
      out <= count_next;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      done  <= done_next;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count_dec;
    done_next  = 1'b0;
    if (load) begin
      count_next = in;
      state_next = (in != '0) ? ST_RUN : ST_DONE;
    end else if (busy && go) begin
      if (out == Width'(1)) begin
        done_next = 1'b1;
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
        count_next = reload;
`else
        count_next = '0;
        state_next = ST_DONE;
`endif
      end else if (out == '0) begin
        // Unreachable from a legal load; park safely instead of wrapping.
        count_next = '0;
        state_next = ST_DONE;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_down_counter.sv
//------------------------------------------------------------------------------
// Module   : tb_down_counter
// Brief    : Vector-table bench with an expected-value queue for down_counter.
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_down_counter;

  typedef struct {
    logic        rst;
    logic        ld;
    logic        g;
    logic [31:0] din;
    logic [31:0] e_out;
    logic        e_busy;
    logic        e_zero;
    logic        e_done;
  } vec_t;

  logic        clock;
  logic        reset;
  logic        load;
  logic        go;
  logic [31:0] in;
  logic [31:0] out;
  logic        busy;
  logic        zero;
  logic        done;

  int checks = 0;
  int errors = 0;

  vec_t vecs[$];
  vec_t sb[$];

  down_counter #(.Width(32)) dut (
    .clock (clock),
    .reset (reset),
    .load  (load),
    .go    (go),
    .in    (in),
    .out   (out),
    .busy  (busy),
    .zero  (zero),
    .done  (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic void add(logic r, logic l, logic g, logic [31:0] d,
                              logic [31:0] eo, logic eb, logic ez, logic ed);
    vec_t v;
    v.rst = r; v.ld = l; v.g = g; v.din = d;
    v.e_out = eo; v.e_busy = eb; v.e_zero = ez; v.e_done = ed;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    vec_t e;
    @(negedge clock);
    reset = v.rst; load = v.ld; go = v.g; in = v.din;
    sb.push_back(v);
    @(posedge clock);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard[%0d]: queue empty, expected an entry", idx);
    end else begin
      e = sb.pop_front();
      check($sformatf("out[%0d]", idx),  out,          e.e_out);
      check($sformatf("busy[%0d]", idx), {31'd0, busy}, {31'd0, e.e_busy});
      check($sformatf("zero[%0d]", idx), {31'd0, zero}, {31'd0, e.e_zero});
      check($sformatf("done[%0d]", idx), {31'd0, done}, {31'd0, e.e_done});
    end
  endtask

  initial begin
    int pulses;
    vec_t v;
    reset = 1'b1; load = 1'b1; go = 1'b1; in = 32'd5;

    // rst ld go in            out          busy zero done
    add(1, 1, 1, 32'd5,        32'd0,        0, 1, 0);   // reset beats load
    add(0, 1, 1, 32'd0,        32'd0,        0, 1, 0);   // zero-length load
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 0);   // no wrap in DONE
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 0);
    add(0, 1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 0);   // max load
    add(0, 0, 1, 32'd0,        32'hFFFFFFFE, 1, 0, 0);
    add(0, 1, 0, 32'd5,        32'd5,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd4,        1, 0, 0);
    add(1, 1, 1, 32'd5,        32'd0,        0, 1, 0);   // abort mid-run
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 0);   // IDLE ignores go
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    add(0, 1, 1, 32'd3,        32'd3,        1, 0, 0);
    for (int k = 1; k <= 9; k++)
      add(0, 0, 1, 32'd0, (k % 3 == 0) ? 32'd3 : 32'(3 - (k % 3)), 1, 0, (k % 3 == 0));
    add(0, 1, 1, 32'd6,        32'd6,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd5,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd4,        1, 0, 0);
    add(0, 1, 1, 32'd2,        32'd2,        1, 0, 0);   // restart
    add(0, 0, 1, 32'd0,        32'd1,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd2,        1, 0, 1);
`else
    add(0, 1, 1, 32'd3,        32'd3,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd2,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd1,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 1);
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 0);
    add(0, 1, 0, 32'd4,        32'd4,        1, 0, 0);   // go 1,0,0,1,1,1
    add(0, 0, 1, 32'd0,        32'd3,        1, 0, 0);
    add(0, 0, 0, 32'd0,        32'd3,        1, 0, 0);
    add(0, 0, 0, 32'd0,        32'd3,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd2,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd1,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 1);
    add(0, 0, 0, 32'd0,        32'd0,        0, 1, 0);
    add(0, 1, 1, 32'd6,        32'd6,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd5,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd4,        1, 0, 0);
    add(0, 1, 1, 32'd2,        32'd2,        1, 0, 0);   // restart
    add(0, 0, 1, 32'd0,        32'd1,        1, 0, 0);
    add(0, 0, 1, 32'd0,        32'd0,        0, 1, 1);
`endif

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // Pulse count over a longer run: exactly one pulse unless auto-reloading.
    v.rst = 0; v.ld = 1; v.g = 1; v.din = 32'd2;
    v.e_out = 32'd2; v.e_busy = 1; v.e_zero = 0; v.e_done = 0;
    apply(v, 900);
    pulses = 0;
    @(negedge clock);
    load = 1'b0; go = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clock);
      #1;
      if (done) pulses++;
    end
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    check("done_pulse_count", pulses, 32'd3);
    check("busy_after_run", {31'd0, busy}, 32'd1);
`else
    check("done_pulse_count", pulses, 32'd1);
    check("busy_after_run", {31'd0, busy}, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
